// File: rtl/uart_rx_os16.sv
// uart_rx_os16 - 16x oversampling UART receiver (8N1, LSB first).
//
// Each bit is sampled at oversample counts 7, 8 and 9 and decided by a
// 2-of-3 vote. A start bit that does not hold up to mid-bit is treated as
// noise. A stop bit sampled 0 raises frame_err. Good bytes go into a small
// FIFO that is drained through a valid/ready handshake.
//
// Ports:
//   clk        system clock
//   rst_       asynchronous active-low reset
//   rxd        serial input, idles high, asynchronous to clk
//   rx_data    byte at the FIFO head (0 when empty)
//   rx_valid   FIFO not empty
//   rx_ready   consumer accept; pop on rx_valid && rx_ready
//   frame_err  1-clk pulse: stop bit sampled 0
//   overrun    1-clk pulse: byte dropped, FIFO full
//   busy       receiving a frame (START/DATA/STOP)
//   fill       FIFO occupancy
module uart_rx_os16 #(
  parameter int OS_DIV     = 326,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_,
  input  logic                          rxd,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fill
);

  localparam int DIV_W = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_SYNC  = 3'd0,
    S_IDLE  = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer; resets to the idle level so reset never looks like a
  // start bit.
  // ---------------------------------------------------------------------------
  logic rxd_meta, rxd_s;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Oversample tick: free-running divider, 1-clk pulse on wrap.
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_W'(OS_DIV - 1));

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_t     state, state_nxt;
  logic [3:0] os_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic       smp7, smp8;
  logic       maj;
  logic       push;
  logic       ferr_set;

  // 2-of-3 vote; the third sample is the live line at os_cnt 9.
  assign maj = (smp7 & smp8) | (smp7 & rxd_s) | (smp8 & rxd_s);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= S_SYNC;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (tick) begin
      unique case (state)
        S_SYNC:  if (rxd_s)  state_nxt = S_IDLE;
        S_IDLE:  if (!rxd_s) state_nxt = S_START;
        S_START: begin
          if (os_cnt == 4'd9 && maj) state_nxt = S_IDLE;   // false start
          else if (os_cnt == 4'd15)  state_nxt = S_DATA;
        end
        S_DATA:  if (os_cnt == 4'd15 && bit_idx == 3'd7) state_nxt = S_STOP;
        // Leave at mid-stop so a slightly fast transmitter's next start
        // edge is not missed. A low stop bit may be a break: resync first.
        S_STOP:  if (os_cnt == 4'd9) state_nxt = maj ? S_IDLE : S_SYNC;
        default: state_nxt = S_SYNC;
      endcase
    end
  end

  always_comb begin
    busy     = (state == S_START) || (state == S_DATA) || (state == S_STOP);
    push     = tick && (state == S_STOP) && (os_cnt == 4'd9) && maj;
    ferr_set = tick && (state == S_STOP) && (os_cnt == 4'd9) && !maj;
  end

  // Bit-timing datapath. os_cnt wraps 15->0 on its own, which lines up the
  // START->DATA, DATA->DATA and DATA->STOP boundaries without extra loads.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      os_cnt  <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      smp7    <= 1'b1;
      smp8    <= 1'b1;
    end else if (tick) begin
      // The tick that first sees 0 counts as sample 0 of the start bit.
      if (state == S_IDLE) os_cnt <= 4'd1;
      else                 os_cnt <= os_cnt + 4'd1;

      if (os_cnt == 4'd7) smp7 <= rxd_s;
      if (os_cnt == 4'd8) smp8 <= rxd_s;

      if (state == S_START && os_cnt == 4'd15) bit_idx <= '0;
      if (state == S_DATA) begin
        if (os_cnt == 4'd9)  shreg[bit_idx] <= maj;
        if (os_cnt == 4'd15) bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO. A push into a full FIFO still lands if the head is popped
  // in the same clk.
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, pop, push_ok, ovr_set;

  assign full     = (fill == (AW+1)'(FIFO_DEPTH));
  assign rx_valid = (fill != '0);
  assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;
  assign pop      = rx_valid && rx_ready;
  assign push_ok  = push && (!full || pop);
  assign ovr_set  = push && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_set;
      overrun   <= ovr_set;
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
`timescale 1ns/1ps
module tb_uart_rx_os16;

  localparam int OS_DIV     = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int BT         = 32;   // clks per bit at nominal rate
  localparam int GAP        = 40;   // idle clks after each frame

  logic       clk = 1'b0;
  logic       rst_;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  logic [2:0] fill;

  int checks = 0;
  int errors = 0;

  uart_rx_os16 #(.OS_DIV(OS_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_(rst_), .rxd(rxd),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun(overrun), .busy(busy), .fill(fill)
  );

  always #5 clk = ~clk;

  // free-running cycle count, used only to align stimulus
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // event monitor
  logic [7:0] popq[$];
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  always @(negedge clk) begin
    if (rst_) begin
      if (rx_valid && rx_ready) popq.push_back(rx_data);
      if (frame_err) ferr_cnt++;
      if (overrun)   ovr_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive the first nclk clocks of a frame; called and returns at a negedge.
  task automatic drive_bits(input logic [7:0] d, input logic stop, input int bclk, input int nclk);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int i = 0; i < nclk; i++) begin
      rxd = (i / bclk < 10) ? fr[i / bclk] : 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop, input int bclk);
    drive_bits(d, stop, bclk, 10 * bclk);
    rxd = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic clear_mon();
    popq.delete();
    ferr_cnt = 0;
    ovr_cnt  = 0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         bclk;
    int         exp_pops;
    logic [7:0] exp_data;
    int         exp_ferr;
  } vec_t;

  vec_t vt[9];

  initial begin
    logic [7:0] exp4 [4];
    int s4, s5, c4, tp;
    bit found;

    vt[0] = '{8'h41, 1'b1, 32, 1, 8'h41, 0};
    vt[1] = '{8'h41, 1'b1, 31, 1, 8'h41, 0};
    vt[2] = '{8'h41, 1'b1, 33, 1, 8'h41, 0};
    vt[3] = '{8'h00, 1'b1, 32, 1, 8'h00, 0};
    vt[4] = '{8'hFF, 1'b1, 31, 1, 8'hFF, 0};
    vt[5] = '{8'hA5, 1'b1, 33, 1, 8'hA5, 0};
    vt[6] = '{8'h5A, 1'b1, 32, 1, 8'h5A, 0};
    vt[7] = '{8'h55, 1'b0, 32, 0, 8'h00, 1};   // bad stop bit, then line high
    vt[8] = '{8'h48, 1'b1, 32, 1, 8'h48, 0};   // must recover after the error

    // ---- reset state
    rst_ = 1'b0; rxd = 1'b1; rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fill", fill, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    rst_ = 1'b1;
    repeat (10) @(negedge clk);

    // ---- table: single frames with rx_ready=1, timing skew, framing error
    rx_ready = 1'b1;
    foreach (vt[i]) begin
      clear_mon();
      send_byte(vt[i].data, vt[i].stop, vt[i].bclk);
      chk($sformatf("v%0d_pops", i), popq.size(), vt[i].exp_pops);
      if (vt[i].exp_pops == 1 && popq.size() == 1)
        chk($sformatf("v%0d_data", i), popq[0], vt[i].exp_data);
      chk($sformatf("v%0d_ferr", i), ferr_cnt, vt[i].exp_ferr);
      chk($sformatf("v%0d_ovr", i), ovr_cnt, 0);
      chk($sformatf("v%0d_busy", i), busy, 0);
      chk($sformatf("v%0d_fill", i), fill, 0);
    end

    // ---- false start: 4-clk glitch
    clear_mon();
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    chk("glitch_busy_hi", busy, 1);
    repeat (60) @(negedge clk);
    chk("glitch_busy_lo", busy, 0);
    chk("glitch_fill", fill, 0);
    chk("glitch_pops", popq.size(), 0);
    chk("glitch_flags", ferr_cnt + ovr_cnt, 0);

    // ---- overrun with rx_ready=0, then drain
    rx_ready = 1'b0;
    clear_mon();
    exp4 = '{8'h48, 8'h45, 8'h4C, 8'h4C};
    foreach (exp4[i]) send_byte(exp4[i], 1'b1, BT);
    chk("ovr_fill4", fill, 4);
    chk("ovr_none_yet", ovr_cnt, 0);
    send_byte(8'h4F, 1'b1, BT);
    chk("ovr_pulse", ovr_cnt, 1);
    chk("ovr_fill_still4", fill, 4);
    chk("ovr_ferr", ferr_cnt, 0);
    foreach (exp4[i]) begin
      chk($sformatf("drain%0d_valid", i), rx_valid, 1);
      chk($sformatf("drain%0d_data", i), rx_data, exp4[i]);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
    chk("drain_empty_valid", rx_valid, 0);
    chk("drain_empty_data", rx_data, 0);
    rx_ready = 1'b1;                       // pop on empty is ignored
    repeat (3) @(negedge clk);
    rx_ready = 1'b0;
    chk("drain_empty_fill", fill, 0);

    // ---- push and pop in the same clk while full
    clear_mon();
    send_byte(8'h10, 1'b1, BT);
    send_byte(8'h20, 1'b1, BT);
    send_byte(8'h30, 1'b1, BT);
    if (cyc[0]) @(negedge clk);
    s4 = cyc; c4 = 0; found = 0;
    fork
      send_byte(8'h40, 1'b1, BT);
      begin
        for (int k = 0; k < 12 * BT; k++) begin
          @(negedge clk);
          if (fill == 3'd4) begin c4 = cyc; found = 1; break; end
        end
      end
    join
    chk("same_clk_measure", found, 1);
    if (cyc[0]) @(negedge clk);
    s5 = cyc;
    tp = s5 + (c4 - s4) - 1;
    fork
      send_byte(8'h50, 1'b1, BT);
      begin
        if (found) begin
          for (int k = 0; k < 12 * BT && cyc != tp; k++) @(negedge clk);
          rx_ready = 1'b1;
          @(negedge clk);
          rx_ready = 1'b0;
        end
      end
    join
    chk("same_clk_ovr", ovr_cnt, 0);
    chk("same_clk_fill", fill, 4);
    chk("same_clk_head", rx_data, 8'h20);
    exp4 = '{8'h20, 8'h30, 8'h40, 8'h50};
    foreach (exp4[i]) begin
      chk($sformatf("same_clk_drain%0d", i), rx_data, exp4[i]);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
    chk("same_clk_empty", rx_valid, 0);

    // ---- asynchronous reset mid-frame
    clear_mon();
    send_byte(8'h11, 1'b1, BT);
    send_byte(8'h22, 1'b1, BT);
    drive_bits(8'h33, 1'b1, BT, BT * 4 + BT / 2);   // into data bit 3
    chk("arst_pre_busy", busy, 1);
    chk("arst_pre_fill", fill, 2);
    #1 rst_ = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_fill", fill, 0);
    chk("arst_valid", rx_valid, 0);
    chk("arst_data", rx_data, 0);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst_ = 1'b1;
    repeat (10) @(negedge clk);
    clear_mon();
    rx_ready = 1'b1;
    send_byte(8'h4F, 1'b1, BT);
    chk("arst_after_pops", popq.size(), 1);
    if (popq.size() == 1) chk("arst_after_data", popq[0], 8'h4F);
    chk("arst_after_ferr", ferr_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
